sdu_host_tx: RTL and testbench

- Host-side command transmitter for the serial debug unit. It is the initiator end of the link whose responder is the debug command processor.
- Accepts one command (ASCII opcode plus optional 32-bit address) over a valid/ready handshake.
- Formats the command as an ASCII line and serialises it as UART 8N1 onto txd, which drives the debug unit's receive line in simulation and loopback test tops.

---
 rtl/sdu_host_pkg.sv | 29 ++
 rtl/sdu_baud_gen.sv | 40 ++++
 rtl/sdu_host_tx.sv | 151 +++++++++++++++
 tb/tb_sdu_host_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdu_host_pkg.sv
// Shared definitions for the serial debug unit host transmitter.
// Optional build macro: SDU_HOST_LF_EN (append LF after CR on every line).
package sdu_host_pkg;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

`ifdef SDU_HOST_LF_EN
  localparam int MAX_BYTES   = 12;
  localparam int SHORT_BYTES = 3;
`else
  localparam int MAX_BYTES   = 11;
  localparam int SHORT_BYTES = 2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/sdu_baud_gen.sv
// Bit-period timer: reloads on load_i and flags the last cycle of each bit.
// The counter only moves while a bit is in progress, so bit edges stay
// aligned to the command acceptance edge.
module sdu_baud_gen #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: reload on a new bit, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && (cnt_q == 16'd0);

endmodule

// File: rtl/sdu_host_tx.sv
// Host-side command transmitter: formats "<op>[ <8 hex>]\r" and sends it
// as UART 8N1 on txd. Optional build macro: SDU_HOST_LF_EN adds "\n".
module sdu_host_tx
  import sdu_host_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [7:0]  cmd_op,
  input  logic        cmd_has_addr,
  input  logic [31:0] cmd_addr,
  output logic        txd,
  output logic        busy,
  output logic        byte_done
);

  localparam logic [3:0] LAST_LONG  = 4'(MAX_BYTES - 1);
  localparam logic [3:0] LAST_SHORT = 4'(SHORT_BYTES - 1);

  tx_state_e   state_q;
  logic        txd_q;
  logic        rdy_q;
  logic [3:0]  idx_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  op_q;
  logic        has_addr_q;
  logic [31:0] addr_q;

  logic        accept;
  logic        bit_end;
  logic        last_byte;
  logic        frame_end;
  logic        baud_load;
  logic [2:0]  nib_sel;
  logic [3:0]  nibble;
  logic [7:0]  cur_byte;

  assign accept    = cmd_vld && rdy_q;
  assign last_byte = (idx_q == (has_addr_q ? LAST_LONG : LAST_SHORT));
  assign frame_end = bit_end && (state_q == STOP) && last_byte;
  assign baud_load = accept || (bit_end && !frame_end);

  sdu_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .load_i    (baud_load),
    .en_i      (state_q != IDLE),
    .bit_end_o (bit_end)
  );

  // Byte to send at the current index; address digits go out MS nibble first.
  always_comb begin
    nib_sel  = 3'(4'd9 - idx_q);
    nibble   = addr_q[{nib_sel, 2'b00} +: 4];
    cur_byte = op_q;
    if (idx_q != 4'd0) begin
      if (has_addr_q) begin
        if (idx_q == 4'd1) begin
          cur_byte = ASC_SP;
        end else if (idx_q <= 4'd9) begin
          cur_byte = hex_ascii(nibble);
        end else if (idx_q == 4'd10) begin
          cur_byte = ASC_CR;
        end else begin
          cur_byte = ASC_LF;
        end
      end else begin
        cur_byte = (idx_q == 4'd1) ? ASC_CR : ASC_LF;
      end
    end
  end

  // Line FSM with registered txd and ready; reset aborts any frame at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b1;
      idx_q   <= 4'd0;
      bit_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= START;
            txd_q   <= 1'b0;
            rdy_q   <= 1'b0;
            idx_q   <= 4'd0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            txd_q   <= cur_byte[0];
            bit_q   <= 3'd0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              txd_q <= shift_q[0];
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_byte) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= START;
              txd_q   <= 1'b0;
              idx_q   <= idx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command capture and data shift register; no reset needed on data.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= cmd_op;
      has_addr_q <= cmd_has_addr;
      addr_q     <= cmd_addr;
    end
    if (bit_end && (state_q == START)) begin
      shift_q <= {1'b0, cur_byte[7:1]};
    end else if (bit_end && (state_q == DATA)) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign txd       = txd_q;
  assign cmd_rdy   = rdy_q;
  assign busy      = ~rdy_q;
  assign byte_done = bit_end && (state_q == STOP);

endmodule

// File: tb/tb_sdu_host_tx.sv
// Bench for sdu_host_tx: a line-level model predicts txd/cmd_rdy/busy/
// byte_done every cycle, a UART receiver decodes txd independently, and
// directed tests pin bytes, frame lengths and pulse counts to literals.
module tb_sdu_host_tx;

  localparam int D  = 4;
  localparam int D2 = 2;
`ifdef SDU_HOST_LF_EN
  localparam int LFX = 1;
`else
  localparam int LFX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        vld2 = 1'b0;
  logic        has = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [31:0] addr = 32'h0;
  logic        rdy, txd, busy, bd;
  logic        rdy2, txd2, busy2, bd2;

  always #5 clk = ~clk;

  sdu_host_tx #(.BAUD_DIV(D)) dut (
    .clk(clk), .rst(rst), .cmd_vld(vld), .cmd_rdy(rdy), .cmd_op(op),
    .cmd_has_addr(has), .cmd_addr(addr), .txd(txd), .busy(busy), .byte_done(bd)
  );

  sdu_host_tx #(.BAUD_DIV(D2)) dut2 (
    .clk(clk), .rst(rst), .cmd_vld(vld2), .cmd_rdy(rdy2), .cmd_op(op),
    .cmd_has_addr(has), .cmd_addr(addr), .txd(txd2), .busy(busy2), .byte_done(bd2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Text of a command line, one byte at a time.
  function automatic logic [7:0] line_byte(input logic [7:0] o, input bit h,
                                           input logic [31:0] a, input int i);
    string hx;
    int    body;
    hx   = "0123456789ABCDEF";
    body = h ? 10 : 1;
    if (i == 0) return o;
    if (h && i == 1) return 8'h20;
    if (h && i < 10) return hx[int'((a >> (4 * (9 - i))) & 32'hF)];
    if (i == body) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic int line_len(input bit h);
    return (h ? 11 : 2) + LFX;
  endfunction

  // UART level of bit k (0=start, 1..8 data LSB first, 9=stop) of a byte.
  function automatic logic uart_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k - 1];
  endfunction

  // Model: per-cycle expected {byte_done, txd}; front entry is the current cycle.
  logic [1:0] exp_q[$];
  bit         model_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_on = 1;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (vld) begin
      for (int i = 0; i < line_len(has); i++) begin
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < D; c++) begin
            exp_q.push_back({(k == 9) && (c == D - 1), uart_bit(line_byte(op, has, addr, i), k)});
          end
        end
      end
    end
  end

  // Cycle compare of {txd, cmd_rdy, busy, byte_done}.
  always @(negedge clk) begin
    logic [3:0] e;
    if (model_on) begin
      if (exp_q.size() != 0) e = {exp_q[0][0], 1'b0, 1'b1, exp_q[0][1]};
      else e = 4'b1100;
      chk("cycle", {28'h0, txd, rdy, busy, bd}, {28'h0, e});
    end
  end

  // Independent UART receiver on txd, sampling mid-bit.
  logic [7:0] rx_q[$];
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (model_on && !rst && txd == 1'b0) begin
      repeat (D / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (D) @(negedge clk);
        b[k] = txd;
      end
      repeat (D) @(negedge clk);
      rx_q.push_back(b);
      repeat (D - D / 2 - 1) @(negedge clk);
    end
  end

  task automatic check_rx(input string nm, input int n, input logic [7:0] e[12]);
    chk({nm, "_nbytes"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) chk({nm, "_byte"}, {24'h0, rx_q[i]}, {24'h0, e[i]});
    end
    rx_q.delete();
  endtask

  // Send one command on the D=4 unit; measure frame length and byte_done count.
  task automatic send(input logic [7:0] o, input bit h, input logic [31:0] a,
                      input bit scramble, output int len, output int pulses);
    @(negedge clk);
    op = o; has = h; addr = a; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    if (scramble) begin
      op = 8'h58; has = ~h; addr = 32'h1234_5678;
    end
    len = 0;
    pulses = 0;
    while (busy && len < 5000) begin
      len++;
      if (bd) pulses++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int len, pulses, cnt, gap;
    logic [7:0] e[12];

    // Reset held three cycles.
    repeat (3) begin
      @(negedge clk);
      chk("reset_idle", {28'h0, txd, rdy, busy, bd}, 32'hC);
    end
    rst = 1'b0;

    // Short command 'P'.
    send(8'h50, 1'b0, 32'h0, 1'b0, len, pulses);
    chk("short_len", len, 80 + 40 * LFX);
    chk("short_pulses", pulses, 2 + LFX);
    e = '{8'h50, 8'h0D, 8'h0A, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_rx("short", 2 + LFX, e);

    // Address command.
    send(8'h44, 1'b1, 32'h0000_001C, 1'b0, len, pulses);
    chk("addr_len", len, 440 + 40 * LFX);
    chk("addr_pulses", pulses, 11 + LFX);
    e = '{8'h44, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h43, 8'h0D, 8'h0A};
    check_rx("addr", 11 + LFX, e);

    // Full hex range, inputs changed right after acceptance.
    send(8'h44, 1'b1, 32'hDEAD_BEEF, 1'b1, len, pulses);
    chk("hex_len", len, 440 + 40 * LFX);
    e = '{8'h44, 8'h20, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    check_rx("hex", 11 + LFX, e);

    // Reset during the data bits of the third byte.
    @(negedge clk);
    op = 8'h44; has = 1'b1; addr = 32'hA5A5_5A5A; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (88) @(negedge clk);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_txd", {31'h0, txd}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {30'h0, rdy, busy}, 32'h2);
    repeat (50) @(negedge clk);
    rx_q.delete();
    send(8'h50, 1'b0, 32'h0, 1'b0, len, pulses);
    chk("after_rst_len", len, 80 + 40 * LFX);
    e = '{8'h50, 8'h0D, 8'h0A, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_rx("after_rst", 2 + LFX, e);

    // Back-to-back with cmd_vld held high.
    @(negedge clk);
    op = 8'h50; has = 1'b0; vld = 1'b1;
    cnt = 0;
    gap = -1;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (gap < 0) gap = i;
      if (i == 150) vld = 1'b0;
    end
    chk("b2b_busy_cycles", cnt, 160 + 80 * LFX);
    chk("b2b_gap_at", gap, 80 + 40 * LFX);
    e = '{8'h50, 8'h0D, 8'h50, 8'h0D, 0, 0, 0, 0, 0, 0, 0, 0};
    if (LFX != 0) e = '{8'h50, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A, 0, 0, 0, 0, 0, 0};
    check_rx("b2b", 4 + 2 * LFX, e);

    // Bit timing with BAUD_DIV=2 on the second unit.
    @(negedge clk);
    op = 8'h50; has = 1'b0; vld2 = 1'b1;
    @(negedge clk);
    vld2 = 1'b0;
    for (int i = 0; i < line_len(1'b0); i++) begin
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < D2; c++) begin
          chk("d2_bit", {29'h0, txd2, busy2, bd2},
              {29'h0, uart_bit(line_byte(8'h50, 1'b0, 32'h0, i), k), 1'b1, (k == 9) && (c == D2 - 1)});
          @(negedge clk);
        end
      end
    end
    chk("d2_end", {29'h0, rdy2, busy2, bd2}, 32'h4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
